aes_out_fifo: RTL and testbench
===============================

AES_OUT_FIFO -- requirements
Module: aes_out_fifo

Interface
REQ-001 Parameter: WIDTH, 34, word width; bits [33:32] are tag bits carried transparently, [31:0] payload.
REQ-002 Parameter: AW, 4, address width; DEPTH = 2^AW = 16 words.
REQ-003 Parameter: AF_MARGIN, 2, almost-full margin in words.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port: i_wr  in  1  write strobe from the AES output controller (its o_wr_out).
REQ-007 Port: i_din  in  WIDTH  write data (the AES top's o_data_out).
REQ-008 Port: o_afull  out  1  almost-full; drives the AES top's i_full_fifo.
REQ-009 Port: o_full  out  1  FIFO holds DEPTH words.
REQ-010 Port: i_rd  in  1  read strobe from host.
REQ-011 Port: o_dout  out  WIDTH  registered read data.
REQ-012 Port: o_dvalid  out  1  o_dout valid, one-cycle pulse per accepted read.
REQ-013 Port: o_empty  out  1  FIFO holds zero words.
REQ-014 Port: o_count  out  AW+1  current occupancy, 0..DEPTH.
REQ-015 Port: i_clr_err  in  1  clears sticky error flags.
REQ-016 Port: o_ovf  out  1  sticky overflow flag.
REQ-017 Port: o_udf  out  1  sticky underflow flag.

Function
REQ-018 Storage SHALL be a DEPTH x WIDTH array with AW-bit write and read pointers that wrap DEPTH-1 -> 0 with no extra logic.
REQ-019 Write accepted iff i_wr=1 and o_full=0 (registered value); i_din stored at wr_ptr, wr_ptr+1 on the next edge.
REQ-020 Read accepted iff i_rd=1 and o_empty=0 (registered value); o_dout loads mem[rd_ptr] and o_dvalid=1 on the next edge, rd_ptr+1.
REQ-021 o_dvalid SHALL be 0 in any cycle following one with no accepted read; o_dout holds its last value.
REQ-022 o_count: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted.
REQ-023 o_full = (o_count==DEPTH); o_empty = (o_count==0); o_afull = (o_count >= DEPTH-AF_MARGIN); all derived from the registered count.
REQ-024 Write while full: data dropped, pointers/count unchanged, o_ovf set next edge; a simultaneous accepted read SHALL NOT make the write accepted.
REQ-025 Read while empty: no pointer/count change, o_dvalid stays 0, o_udf set next edge; a simultaneous write to an empty FIFO is accepted and readable no earlier than the following cycle.
REQ-026 i_clr_err=1 clears o_ovf and o_udf next edge; a new error event in the same cycle wins (flag set).
REQ-027 Data SHALL leave in exact write order, all WIDTH bits including tags unmodified.

Reset
REQ-028 rst_n=0 at a rising edge: pointers 0, o_count 0, o_empty 1, o_full 0, o_afull 0, o_dout 0, o_dvalid 0, o_ovf 0, o_udf 0; memory contents not reset.
REQ-029 Reset mid-operation SHALL discard all stored words; strobes during reset are ignored and raise no errors.

Verification
REQ-030 Reset, write 34'h1_0000_0001, 34'h0_0000_0002, 34'h2_0000_0003, then read 3 -> o_dout sequence identical, o_dvalid one cycle after each i_rd, o_empty=1 after third read.
REQ-031 Write 14 words -> o_afull=1 at count 14, o_full=0; write 2 more -> o_full=1, o_count=16.
REQ-032 Full FIFO, assert i_wr and i_rd same cycle -> read accepted, write dropped, o_ovf=1, o_count=15.
REQ-033 Empty FIFO, i_rd=1 with i_wr=1 -> o_udf=1, o_dvalid=0, o_count=1; i_clr_err -> o_udf=0.
REQ-034 Stream 40 words with interleaved reads -> pointer wrap, no loss or reorder, o_count matches model every cycle.
REQ-035 Write 5 words, pulse rst_n=0 one cycle -> o_count=0, o_empty=1, next read sets o_udf.

Source files
------------

// File: rtl/aes_out_fifo.sv
// AES output FIFO: buffers tagged result words for the host.
// Registered read port, occupancy count and sticky error flags.
module aes_out_fifo #(
  parameter int WIDTH     = 34,
  parameter int AW        = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_afull,
  output logic             o_full,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dvalid,
  output logic             o_empty,
  output logic [AW:0]      o_count,
  input  logic             i_clr_err,
  output logic             o_ovf,
  output logic             o_udf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT =
    (AW+1)'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  // Flags come from the registered count only
  assign o_count = count;
  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);
  assign o_afull = (count >= AF_CNT);

  assign wr_ok = i_wr & ~o_full;
  assign rd_ok = i_rd & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      o_dout   <= '0;
      o_dvalid <= 1'b0;
      o_ovf    <= 1'b0;
      o_udf    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        o_dout <= mem[rd_ptr];
      end
      o_dvalid <= rd_ok;
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      // A new error in the clear cycle keeps the flag set
      o_ovf <= (i_wr & o_full) | (o_ovf & ~i_clr_err);
      o_udf <= (i_rd & o_empty) | (o_udf & ~i_clr_err);
    end
  end

endmodule

// File: tb/tb_aes_out_fifo.sv
// Directed bench for aes_out_fifo with a small queue model.
// Directed vectors plus per-cycle model comparisons.
module tb_aes_out_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_wr;
  logic [33:0] i_din;
  logic        o_afull;
  logic        o_full;
  logic        i_rd;
  logic [33:0] o_dout;
  logic        o_dvalid;
  logic        o_empty;
  logic [4:0]  o_count;
  logic        i_clr_err;
  logic        o_ovf;
  logic        o_udf;

  int n_run  = 0;
  int n_fail = 0;

  logic [33:0] q[$];
  int          m_cnt;
  logic [33:0] m_dout;
  logic        m_dv;
  logic        m_ovf;
  logic        m_udf;

  always #5 clk = ~clk;

  aes_out_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr      (i_wr),
    .i_din     (i_din),
    .o_afull   (o_afull),
    .o_full    (o_full),
    .i_rd      (i_rd),
    .o_dout    (o_dout),
    .o_dvalid  (o_dvalid),
    .o_empty   (o_empty),
    .o_count   (o_count),
    .i_clr_err (i_clr_err),
    .o_ovf     (o_ovf),
    .o_udf     (o_udf)
  );

  task automatic chk(string tag,
                     logic [63:0] act,
                     logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  task automatic cyc(logic wr, logic [33:0] din,
                     logic rd, logic clr = 1'b0);
    bit wok;
    bit rok;
    i_wr      = wr;
    i_din     = din;
    i_rd      = rd;
    i_clr_err = clr;
    wok = wr && (m_cnt != 16);
    rok = rd && (m_cnt != 0);
    m_ovf = (wr && m_cnt == 16) || (m_ovf && !clr);
    m_udf = (rd && m_cnt == 0) || (m_udf && !clr);
    m_dv  = rok;
    if (rok) m_dout = q.pop_front();
    if (wok) q.push_back(din);
    m_cnt = q.size();
    @(posedge clk);
    #1;
    i_wr      = 1'b0;
    i_rd      = 1'b0;
    i_clr_err = 1'b0;
    chk("count", o_count, m_cnt);
    chk("dvalid", o_dvalid, m_dv);
    chk("dout", o_dout, m_dout);
    chk("ovf", o_ovf, m_ovf);
    chk("udf", o_udf, m_udf);
    chk("empty", o_empty, m_cnt == 0);
    chk("full", o_full, m_cnt == 16);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_wr  = 1'b1;
    i_rd  = 1'b1;
    i_din = 34'h3_DEAD_BEEF;
    i_clr_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_wr  = 1'b0;
    i_rd  = 1'b0;
    q.delete();
    m_cnt  = 0;
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_afull", o_afull, 0);
    chk("rst_dout", o_dout, 0);
    chk("rst_dvalid", o_dvalid, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_udf", o_udf, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_wr = 1'b0;
    i_rd = 1'b0;
    i_din = '0;
    i_clr_err = 1'b0;
    do_reset();

    // ordered readback with tag bits
    cyc(1, 34'h1_0000_0001, 0);
    cyc(1, 34'h0_0000_0002, 0);
    cyc(1, 34'h2_0000_0003, 0);
    chk("w3_count", o_count, 3);
    cyc(0, '0, 1);
    chk("r1", o_dout, 34'h1_0000_0001);
    chk("r1_dv", o_dvalid, 1);
    cyc(0, '0, 0);
    chk("r1_dv_drop", o_dvalid, 0);
    chk("r1_hold", o_dout, 34'h1_0000_0001);
    cyc(0, '0, 1);
    chk("r2", o_dout, 34'h0_0000_0002);
    cyc(0, '0, 1);
    chk("r3", o_dout, 34'h2_0000_0003);
    chk("r3_empty", o_empty, 1);

    // fill to almost-full then full
    for (int i = 0; i < 14; i++) begin
      cyc(1, {2'(i), 32'hB000_0000 + i}, 0);
      if (i == 12) chk("af_13", o_afull, 0);
    end
    chk("af_14", o_afull, 1);
    chk("full_14", o_full, 0);
    chk("cnt_14", o_count, 14);
    cyc(1, 34'h1_B000_000E, 0);
    cyc(1, 34'h2_B000_000F, 0);
    chk("full_16", o_full, 1);
    chk("cnt_16", o_count, 16);

    // write+read while full: only read accepted
    cyc(1, 34'h3_FFFF_FFFF, 1);
    chk("fr_ovf", o_ovf, 1);
    chk("fr_cnt", o_count, 15);
    chk("fr_dout", o_dout, 34'h0_B000_0000);
    cyc(0, '0, 0, 1);
    chk("ovf_clr", o_ovf, 0);
    while (m_cnt > 0) cyc(0, '0, 1);

    // read on empty with write; clear vs new error
    cyc(1, 34'h2_1234_5678, 1);
    chk("er_udf", o_udf, 1);
    chk("er_dv", o_dvalid, 0);
    chk("er_cnt", o_count, 1);
    cyc(0, '0, 0, 1);
    chk("udf_clr", o_udf, 0);
    cyc(0, '0, 1);
    chk("er_data", o_dout, 34'h2_1234_5678);
    cyc(0, '0, 1, 1);
    chk("clr_vs_err", o_udf, 1);
    cyc(0, '0, 0, 1);

    // 40-word stream with interleaved reads
    for (int i = 0; i < 40; i++) begin
      cyc(1, {2'(i), 32'hA000_0000 + i}, (i % 4) != 0);
    end
    for (int i = 0; i < 20 && m_cnt > 0; i++) begin
      cyc(0, '0, 1);
    end
    chk("st_last", o_dout, 34'h3_A000_0027);
    chk("st_empty", o_empty, 1);

    // reset mid-operation
    for (int i = 0; i < 5; i++) begin
      cyc(1, {2'(i), 32'hC000_0000 + i}, 0);
    end
    chk("pre_rst", o_count, 5);
    do_reset();
    cyc(0, '0, 1);
    chk("post_rst_udf", o_udf, 1);
    chk("post_rst_dv", o_dvalid, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
